// File: rtl/reg_1r1w_pkg.sv
// Shared types for the 1R1W register-file master: FSM states and shadow sizing.
package reg_1r1w_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // The array commits a write two edges after wr; the shadow must cover that window.
  localparam int SHADOW_N = 2;

endpackage

// File: rtl/reg_1r1w_fwd.sv
// Write shadow for the array's two-stage write path with newest-first address match.
module reg_1r1w_fwd
  import reg_1r1w_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADRWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADRWID-1:0] wa,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADRWID-1:0] raddr,
  output logic              hit,
  output logic [WIDTH-1:0]  fwd_data
);

  typedef struct packed {
    logic              vld;
    logic [ADRWID-1:0] addr;
    logic [WIDTH-1:0]  data;
  } shadow_t;

  shadow_t sh [SHADOW_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SHADOW_N; i++) sh[i] <= '0;
    end else begin
      sh[0] <= shadow_t'{vld: wr, addr: wa, data: wdata};
      for (int i = 1; i < SHADOW_N; i++) sh[i] <= sh[i-1];
    end
  end

  // Walk oldest to newest so later matches override; same-cycle write wins last.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = SHADOW_N - 1; i >= 0; i--) begin
      if (sh[i].vld && sh[i].addr == raddr) begin
        hit      = 1'b1;
        fwd_data = sh[i].data;
      end
    end
    if (wr && wa == raddr) begin
      hit      = 1'b1;
      fwd_data = wdata;
    end
  end

endmodule

// File: rtl/reg_1r1w_master.sv
// Initiator for a 1R1W register array: init sweep, client write/read handshakes,
// write forwarding across the array's write latency and fixed-latency read return.
module reg_1r1w_master
  import reg_1r1w_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               ADRWID   = 8,
  parameter int               DEPTH    = 256,
  parameter int               RD_LAT   = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADRWID-1:0] wreq_addr,
  input  logic [WIDTH-1:0]  wreq_data,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADRWID-1:0] rreq_addr,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              init_done,
  output logic              wr,
  output logic [ADRWID-1:0] wa,
  output logic [WIDTH-1:0]  data_in,
  output logic              rd,
  output logic [ADRWID-1:0] ra,
  input  logic [WIDTH-1:0]  data_out
);

  typedef struct packed {
    logic             vld;
    logic             hit;
    logic [WIDTH-1:0] data;
  } rpipe_t;

  localparam logic [ADRWID:0] LAST = (ADRWID + 1)'(DEPTH - 1);

  state_e            state, state_nxt;
  logic [ADRWID:0]   cnt, cnt_nxt;
  logic              fwd_hit;
  logic [WIDTH-1:0]  fwd_data;
  rpipe_t            rp [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= (state_nxt == S_RUN);
    end
  end

  // Sweep writes are gated by rst so the array port stays quiet while held in reset.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wr         = 1'b0;
    wa         = '0;
    data_in    = '0;
    rd         = 1'b0;
    ra         = '0;
    wreq_ready = 1'b0;
    rreq_ready = 1'b0;
    case (state)
      S_INIT: begin
        if (!rst) begin
          wr      = 1'b1;
          wa      = cnt[ADRWID-1:0];
          data_in = INIT_VAL;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        wreq_ready = 1'b1;
        rreq_ready = 1'b1;
        if (wreq_valid) begin
          wr      = 1'b1;
          wa      = wreq_addr;
          data_in = wreq_data;
        end
        if (rreq_valid) begin
          rd = 1'b1;
          ra = rreq_addr;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  reg_1r1w_fwd #(
    .WIDTH  (WIDTH),
    .ADRWID (ADRWID)
  ) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .wa       (wa),
    .wdata    (data_in),
    .raddr    (rreq_addr),
    .hit      (fwd_hit),
    .fwd_data (fwd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) rp[i] <= '0;
    end else begin
      rp[0] <= rpipe_t'{vld: rd, hit: rd & fwd_hit, data: fwd_data};
      for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
  end

  // Tail aligns with data_out from the array; forwarded data overrides it.
  assign rsp_valid = rp[RD_LAT-1].vld;
  assign rsp_data  = !rp[RD_LAT-1].vld ? '0 :
                     rp[RD_LAT-1].hit  ? rp[RD_LAT-1].data : data_out;

endmodule

// File: tb/tb_reg_1r1w_master.sv
// Scoreboard bench for reg_1r1w_master driving a behavioural 1R1W array.
module tb_reg_1r1w_master;

  localparam int          W  = 32;
  localparam int          AW = 8;
  localparam int          D  = 256;
  localparam int          RL = 2;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;
  assign rst_n = ~rst;

  logic          wreq_valid = 1'b0, wreq_ready, rreq_valid = 1'b0, rreq_ready;
  logic [AW-1:0] wreq_addr = '0, rreq_addr = '0, wa, ra;
  logic [W-1:0]  wreq_data = '0, rsp_data, data_in, data_out;
  logic          rsp_valid, init_done, wr, rd;

  reg_1r1w_master #(.WIDTH(W), .ADRWID(AW), .DEPTH(D), .RD_LAT(RL), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
    .wr(wr), .wa(wa), .data_in(data_in), .rd(rd), .ra(ra), .data_out(data_out)
  );

  // Small instance: DEPTH equals 2^ADRWID, sweep must stop after 4 writes.
  logic       s_wreq_ready, s_rreq_ready, s_rsp_valid, s_init_done, s_wr, s_rd;
  logic [1:0] s_wa, s_ra;
  logic [W-1:0] s_rsp_data, s_data_in;

  reg_1r1w_master #(.WIDTH(W), .ADRWID(2), .DEPTH(4), .RD_LAT(1), .INIT_VAL(32'h0)) dut_s (
    .clk(clk), .rst(rst),
    .wreq_valid(1'b0), .wreq_ready(s_wreq_ready), .wreq_addr(2'd0), .wreq_data('0),
    .rreq_valid(1'b0), .rreq_ready(s_rreq_ready), .rreq_addr(2'd0),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .init_done(s_init_done),
    .wr(s_wr), .wa(s_wa), .data_in(s_data_in), .rd(s_rd), .ra(s_ra), .data_out('0)
  );

  // Behavioural array: write registered then committed (2 edges), read RL cycles.
  logic [W-1:0]  mem [D];
  logic          ws_v;
  logic [AW-1:0] ws_a;
  logic [W-1:0]  ws_d;
  logic [W-1:0]  rdp [RL];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ws_v <= 1'b0;
    else begin
      ws_v <= wr;
      ws_a <= wa;
      ws_d <= data_in;
    end
  end
  always @(posedge clk) if (ws_v) mem[ws_a] <= ws_d;
  always @(posedge clk) begin
    if (rd) rdp[0] <= mem[ra];
    for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
  end
  assign data_out = rdp[RL-1];

  // Reference: flat memory, write-first, response due RL cycles after fire.
  typedef struct { logic [W-1:0] d; int tgt; } exp_t;
  exp_t        q [$];
  logic [W-1:0] ref_mem [D];
  int cyc = 0, checks = 0, passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", n, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) chk("rsp_spurious", 64'(rsp_valid), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.d));
        chk("rsp_lat", 64'(cyc), 64'(e.tgt));
      end
    end else if (q.size() > 0 && q[0].tgt <= cyc) begin
      chk("rsp_missing", 64'(rsp_valid), 64'd1);
      void'(q.pop_front());
    end
  end

  task automatic drive(input logic wv, input logic [AW-1:0] a_w, input logic [W-1:0] d_w,
                       input logic rv, input logic [AW-1:0] a_r);
    @(negedge clk);
    wreq_valid = wv; wreq_addr = a_w; wreq_data = d_w;
    rreq_valid = rv; rreq_addr = a_r;
    if (wv && wreq_ready) ref_mem[a_w] = d_w;
    if (rv && rreq_ready) q.push_back('{ref_mem[a_r], cyc + RL});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Releases reset and follows the sweep until init_done, checking every write.
  task automatic do_sweep(input bit with_small);
    int k, errs, s_errs;
    k = 0; errs = 0; s_errs = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    while (!init_done && k < 400) begin
      if (!(wr && wa == k[AW-1:0] && data_in == IV)) errs++;
      if (with_small) begin
        if (k < 4) begin
          if (!(s_wr && s_wa == k[1:0] && s_data_in == '0 && !s_init_done)) s_errs++;
        end else if (k == 4) begin
          chk("small_sweep_writes", 64'(s_errs), 64'd0);
          chk("small_init_done", 64'({s_init_done, s_wr}), 64'b10);
          chk("small_ready", 64'({s_wreq_ready, s_rreq_ready}), 64'b11);
          chk("small_idle", 64'({s_rd, s_ra, s_rsp_valid, s_rsp_data}), 64'd0);
        end
      end
      @(negedge clk);
      k++;
    end
    chk("sweep_writes", 64'(errs), 64'd0);
    chk("sweep_len", 64'(k), 64'(D));
    chk("init_done", 64'(init_done), 64'd1);
    chk("ready_run", 64'({wreq_ready, rreq_ready}), 64'b11);
    for (int i = 0; i < D; i++) ref_mem[i] = IV;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({wr, rd, init_done, wreq_ready, rreq_ready, rsp_valid}), 64'd0);
    do_sweep(1'b1);

    drive(1'b0, '0, '0, 1'b1, 8'h7F);
    idle(1);
    drive(1'b1, 8'h10, 32'h1234_5678, 1'b1, 8'h10);
    drive(1'b0, '0, '0, 1'b1, 8'h10);
    drive(1'b0, '0, '0, 1'b1, 8'h10);
    idle(1);
    drive(1'b1, 8'h20, 32'd1, 1'b0, '0);
    drive(1'b1, 8'h20, 32'd2, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b1, 8'h20);
    idle(1);
    for (int i = 0; i < 16; i++) drive(1'b1, AW'(i), W'(i), 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(1'b0, '0, '0, 1'b1, AW'(i));
    idle(4);

    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
    idle(3);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1, AW'(i));
    idle(4);

    // Reset in the middle of the sweep.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_outputs", 64'({wr, init_done, rsp_valid, wreq_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!(wr && wa == 8'd100) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr100", 64'(wa), 64'd100);
    rst = 1'b1;
    #1;
    chk("rst_mid_sweep", 64'({wr, init_done}), 64'd0);
    do_sweep(1'b0);

    // Reset with two reads in flight.
    drive(1'b0, '0, '0, 1'b1, 8'h7F);
    drive(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1, 8'h10);
    #1;
    rst = 1'b1;
    q.delete();
    wreq_valid = 1'b0;
    rreq_valid = 1'b0;
    #1;
    chk("rst_drop_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_rsp", 64'(rsp_valid), 64'd0);
    end
    do_sweep(1'b0);
    drive(1'b0, '0, '0, 1'b1, 8'h10);
    idle(5);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
